sp_ram: RTL and testbench

Single-port synchronous static RAM with a registered read port, parameterized in data width and address width. It serves as generic on-chip storage: one shared address bus, an active-low chip select, and a write/read select. The storage array is directly loadable from a hex file through its hierarchical name, so benches can preload contents without bus cycles.

---
 rtl/sp_ram.sv | 50 +++++
 tb/tb_sp_ram.sv | 119 +++++++++++
 2 files changed

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous RAM with registered read data
// The array is file-loadable through its hierarchical name and is never reset.
module sp_ram #(
    parameter int WD = 8,
    parameter int AD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs_n,
    input  logic          w_r_n,
    input  logic [AD-1:0] addr,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout
);

    localparam int DEPTH = 1 << AD;

    logic [WD-1:0] buffer [0:DEPTH-1];

    logic          wr_en;
    logic          rd_en;
    logic [WD-1:0] dout_d;
    logic [WD-1:0] dout_q;

    always_comb begin
        wr_en  = !cs_n && w_r_n;
        rd_en  = !cs_n && !w_r_n;
        dout_d = dout_q;
        if (rd_en) begin
            dout_d = buffer[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_sp_ram.sv
// tb/tb_sp_ram.sv - scoreboard bench for sp_ram
// Inputs change on falling edges; dout is checked 1 time unit after each rising edge.
module tb_sp_ram;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       w_r_n;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:15];
    logic [7:0] init [0:15];
    logic [7:0] exp_dout;
    logic [7:0] sb_q [$];

    sp_ram #(.WD(8), .AD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs_n  (cs_n),
        .w_r_n (w_r_n),
        .addr  (addr),
        .din   (din),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, update the model, check after the rising edge.
    task automatic bus_cycle(input string tag, input logic c, input logic w,
                             input logic [3:0] a, input logic [7:0] d);
        logic [7:0] e;
        @(negedge clk);
        cs_n  = c;
        w_r_n = w;
        addr  = a;
        din   = d;
        if (!c && !w) exp_dout = mem[a];
        if (!c && w)  mem[a] = d;
        sb_q.push_back(exp_dout);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(tag, dout, e);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        w_r_n = 1'b0;
        addr  = '0;
        din   = '0;
        exp_dout = '0;

        for (int i = 0; i < 16; i++) begin
            init[i] = 8'($urandom_range(0, 255));
            mem[i]  = init[i];
            dut.buffer[i] = init[i];
        end

        repeat (3) @(posedge clk);
        #1 chk("reset_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) bus_cycle("preload_rd", 1'b0, 1'b0, 4'(i), 8'h00);

        for (int i = 0; i < 16; i++) begin
            bus_cycle("wr_hold", 1'b0, 1'b1, 4'(i), 8'hA0 + 8'(i));
            chk("wr_array", dut.buffer[i], 8'hA0 + 8'(i));
        end

        for (int i = 0; i < 16; i++) bus_cycle("readback", 1'b0, 1'b0, 4'(i), 8'h00);

        for (int i = 0; i < 16; i++) bus_cycle("desel_hold", 1'b1, 1'b1, 4'(i), 8'h55);
        for (int i = 0; i < 16; i++) chk("desel_array", dut.buffer[i], mem[i]);
        bus_cycle("desel_rd3", 1'b0, 1'b0, 4'd3, 8'h00);

        for (int i = 8; i < 12; i++) bus_cycle("pre_rst_rd", 1'b0, 1'b0, 4'(i), 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", dout, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1 chk("rst_held", dout, 8'h00);
        end
        exp_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_cycle("post_rst_rd5", 1'b0, 1'b0, 4'd5, 8'h00);

        bus_cycle("wr7", 1'b0, 1'b1, 4'd7, 8'h3C);
        bus_cycle("rd7_after_wr", 1'b0, 1'b0, 4'd7, 8'h00);
        chk("rd7_value", dout, 8'h3C);

        for (int i = 0; i < 20; i++) begin
            bus_cycle("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
